// File: rtl/spell_mem_arbiter.sv
// rtl/spell_mem_arbiter.sv - two-port arbiter in front of the SPELL internal memory
//
// Purpose: grants port A (CPU core) or port B (debug/host loader) access to the
// SPELL memory, drives and holds the memory request until data_ready, returns
// read data with a one-cycle ack, then waits for data_ready to drop before
// accepting the next request.
//
// Configuration macro: SPELL_ARB_ROUND_ROBIN_EN
//   defined   - round-robin between A and B when both request
//   undefined - fixed priority, B beats A
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_req/a_addr/a_type_data/a_write/a_wdata   port A request
//   a_ack, a_rdata             port A completion pulse and read data
//   b_*                        same as port A, for port B
//   mem_select/mem_addr/mem_type_data/mem_write/mem_wdata  to memory
//   mem_rdata, mem_ready       from memory
//   busy                       high whenever the FSM is not in IDLE
module spell_mem_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_req,
  input  logic [7:0] a_addr,
  input  logic       a_type_data,
  input  logic       a_write,
  input  logic [7:0] a_wdata,
  output logic       a_ack,
  output logic [7:0] a_rdata,
  input  logic       b_req,
  input  logic [7:0] b_addr,
  input  logic       b_type_data,
  input  logic       b_write,
  input  logic [7:0] b_wdata,
  output logic       b_ack,
  output logic [7:0] b_rdata,
  output logic       mem_select,
  output logic [7:0] mem_addr,
  output logic       mem_type_data,
  output logic       mem_write,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ready,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_e;

  state_e     state_q, state_d;
  logic       grant_b_q, grant_b_d;
  logic       mem_select_q, mem_select_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic       mem_type_q, mem_type_d;
  logic       mem_write_q, mem_write_d;
  logic [7:0] mem_wdata_q, mem_wdata_d;
  logic       a_ack_q, a_ack_d;
  logic       b_ack_q, b_ack_d;
  logic [7:0] a_rdata_q, a_rdata_d;
  logic [7:0] b_rdata_q, b_rdata_d;
  logic       busy_q, busy_d;
  logic       pick_b;

`ifdef SPELL_ARB_ROUND_ROBIN_EN
  // 1 = B was granted last; reset value means "A granted last" so B wins first tie.
  logic last_b_q, last_b_d;

  assign pick_b = b_req && (!a_req || !last_b_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_b_q <= 1'b0;
    else        last_b_q <= last_b_d;
  end

  always_comb begin
    last_b_d = last_b_q;
    if (state_q == IDLE && (a_req || b_req)) last_b_d = pick_b;
  end
`else
  assign pick_b = b_req;
`endif

  always_comb begin
    state_d      = state_q;
    grant_b_d    = grant_b_q;
    mem_select_d = mem_select_q;
    mem_addr_d   = mem_addr_q;
    mem_type_d   = mem_type_q;
    mem_write_d  = mem_write_q;
    mem_wdata_d  = mem_wdata_q;
    a_ack_d      = 1'b0;
    b_ack_d      = 1'b0;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          grant_b_d    = pick_b;
          mem_addr_d   = pick_b ? b_addr      : a_addr;
          mem_type_d   = pick_b ? b_type_data : a_type_data;
          mem_write_d  = pick_b ? b_write     : a_write;
          mem_wdata_d  = pick_b ? b_wdata     : a_wdata;
          mem_select_d = 1'b1;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          // Read data is captured for writes too; requesters ignore it then.
          if (grant_b_q) begin
            b_rdata_d = mem_rdata;
            b_ack_d   = 1'b1;
          end else begin
            a_rdata_d = mem_rdata;
            a_ack_d   = 1'b1;
          end
          mem_select_d = 1'b0;
          mem_write_d  = 1'b0;
          state_d      = RELEASE;
        end
      end
      RELEASE: begin
        // Memory must see select low and drop data_ready before the next grant.
        if (!mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_b_q    <= 1'b0;
      mem_select_q <= 1'b0;
      mem_addr_q   <= 8'h00;
      mem_type_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_wdata_q  <= 8'h00;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      a_rdata_q    <= 8'h00;
      b_rdata_q    <= 8'h00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_b_q    <= grant_b_d;
      mem_select_q <= mem_select_d;
      mem_addr_q   <= mem_addr_d;
      mem_type_q   <= mem_type_d;
      mem_write_q  <= mem_write_d;
      mem_wdata_q  <= mem_wdata_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign a_ack         = a_ack_q;
  assign b_ack         = b_ack_q;
  assign a_rdata       = a_rdata_q;
  assign b_rdata       = b_rdata_q;
  assign mem_select    = mem_select_q;
  assign mem_addr      = mem_addr_q;
  assign mem_type_data = mem_type_q;
  assign mem_write     = mem_write_q;
  assign mem_wdata     = mem_wdata_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_spell_mem_arbiter.sv
// tb/tb_spell_mem_arbiter.sv - scoreboard testbench for spell_mem_arbiter
module tb_spell_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req, a_type_data, a_write;
  logic [7:0] a_addr, a_wdata;
  logic       a_ack;
  logic [7:0] a_rdata;
  logic       b_req, b_type_data, b_write;
  logic [7:0] b_addr, b_wdata;
  logic       b_ack;
  logic [7:0] b_rdata;
  logic       mem_select, mem_type_data, mem_write;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_ready = 1'b0;
  logic       busy;

  spell_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_type_data(a_type_data), .a_write(a_write),
    .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_type_data(b_type_data), .b_write(b_write),
    .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_select(mem_select), .mem_addr(mem_addr), .mem_type_data(mem_type_data),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: zero-delay, self-initialises for 600 cycles after power-up.
  localparam int INIT_CYCLES = 600;
  int         init_cnt = 0;
  logic [7:0] data_mem [256];

  function automatic logic [7:0] code_val(input logic [7:0] addr);
    return (addr == 8'h10) ? 8'h5A : 8'hFF;
  endfunction

  always @(posedge clk) begin
    if (init_cnt < INIT_CYCLES) init_cnt <= init_cnt + 1;
    if (!mem_select) mem_ready <= 1'b0;
    else if (init_cnt >= INIT_CYCLES && !mem_ready) begin
      mem_ready <= 1'b1;
      if (mem_write) begin
        if (mem_type_data) data_mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem_wdata;
      end else begin
        mem_rdata <= mem_type_data ? data_mem[mem_addr] : code_val(mem_addr);
      end
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic       port_b;
    logic [7:0] data;
    logic       chk;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  // Scoreboard: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (a_ack || b_ack)) begin
      check("ack_exclusive", {31'd0, a_ack && b_ack}, 32'd0);
      if (sb.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("ack_port", {31'd0, b_ack}, {31'd0, e.port_b});
        if (e.chk) check("rdata", {24'd0, b_ack ? b_rdata : a_rdata}, {24'd0, e.data});
      end
    end
  end

  function automatic exp_t mk(input logic pb, input logic [7:0] d, input logic c);
    exp_t x;
    x.port_b = pb; x.data = d; x.chk = c;
    return x;
  endfunction

  task automatic issue(input logic pb, input logic [7:0] addr, input logic td,
                       input logic wr, input logic [7:0] wd);
    if (pb) begin
      b_addr = addr; b_type_data = td; b_write = wr; b_wdata = wd; b_req = 1'b1;
    end else begin
      a_addr = addr; a_type_data = td; a_write = wr; a_wdata = wd; a_req = 1'b1;
    end
  endtask

  task automatic wait_ack(input int bound, output int at_cyc);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (a_ack || b_ack) begin
        at_cyc = cyc;
        return;
      end
    end
    check("ack_timeout", 32'd0, 32'd1);
    at_cyc = -1;
  endtask

  int c0, t, prev, n;

  initial begin
    rst_n = 1'b0;
    a_req = 0; a_addr = 0; a_type_data = 0; a_write = 0; a_wdata = 0;
    b_req = 0; b_addr = 0; b_type_data = 0; b_write = 0; b_wdata = 0;
    repeat (3) @(negedge clk);
    check("rst_mem_select", {31'd0, mem_select}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_acks", {30'd0, a_ack, b_ack}, 32'd0);
    check("rst_rdata", {16'd0, a_rdata, b_rdata}, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Request during memory init: no ack until init completes, then 0xFF.
    issue(1'b0, 8'h20, 1'b0, 1'b0, 8'h00);
    sb.push_back(mk(1'b0, 8'hFF, 1'b1));
    c0 = cyc;
    wait_ack(2000, t);
    check("init_wait_ge512", {31'd0, (t - c0) >= 512}, 32'd1);
    a_req = 1'b0;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (a_ack || b_ack) n++;
    end
    check("no_dup_ack", n, 32'd0);

    // Single A read of preloaded code address.
    issue(1'b0, 8'h10, 1'b0, 1'b0, 8'h00);
    sb.push_back(mk(1'b0, 8'h5A, 1'b1));
    c0 = cyc;
    wait_ack(50, t);
    check("a_read_latency", t - c0, 32'd3);
    check("sel_low_on_ack", {31'd0, mem_select}, 32'd0);
    a_req = 1'b0;
    @(negedge clk);
    check("busy_in_release", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("busy_back_idle", {31'd0, busy}, 32'd0);

    // B write then B read of the same data address.
    @(negedge clk);
    issue(1'b1, 8'h07, 1'b1, 1'b1, 8'hC3);
    sb.push_back(mk(1'b1, 8'h00, 1'b0));
    @(negedge clk);
    check("wr_select", {31'd0, mem_select}, 32'd1);
    check("wr_mem_write", {31'd0, mem_write}, 32'd1);
    wait_ack(50, t);
    check("wr_write_cleared", {31'd0, mem_write}, 32'd0);
    b_req = 1'b0;
    repeat (2) @(negedge clk);
    issue(1'b1, 8'h07, 1'b1, 1'b0, 8'h00);
    sb.push_back(mk(1'b1, 8'hC3, 1'b1));
    @(negedge clk);
    check("rd_mem_write", {31'd0, mem_write}, 32'd0);
    wait_ack(50, t);
    b_req = 1'b0;
    repeat (2) @(negedge clk);

    // Both ports held for four transactions.
    issue(1'b0, 8'h10, 1'b0, 1'b0, 8'h00);
    issue(1'b1, 8'h07, 1'b1, 1'b0, 8'h00);
`ifdef SPELL_ARB_ROUND_ROBIN_EN
    sb.push_back(mk(1'b1, 8'hC3, 1'b1));
    sb.push_back(mk(1'b0, 8'h5A, 1'b1));
    sb.push_back(mk(1'b1, 8'hC3, 1'b1));
    sb.push_back(mk(1'b0, 8'h5A, 1'b1));
`else
    for (int i = 0; i < 4; i++) sb.push_back(mk(1'b1, 8'hC3, 1'b1));
`endif
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ack(50, t);
      if (i > 0) check("contend_spacing", t - prev, 32'd5);
      prev = t;
    end
`ifdef SPELL_ARB_ROUND_ROBIN_EN
    a_req = 1'b0;
    b_req = 1'b0;
`else
    b_req = 1'b0;
    sb.push_back(mk(1'b0, 8'h5A, 1'b1));
    wait_ack(50, t);
    check("starved_a_spacing", t - prev, 32'd5);
    a_req = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Asynchronous reset while in ACCESS.
    issue(1'b0, 8'h10, 1'b0, 1'b0, 8'h00);
    sb.push_back(mk(1'b0, 8'h5A, 1'b1));
    @(negedge clk);
    check("pre_reset_select", {31'd0, mem_select}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_select", {31'd0, mem_select}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_acks", {30'd0, a_ack, b_ack}, 32'd0);
    sb.delete();
    a_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 8'h10, 1'b0, 1'b0, 8'h00);
    sb.push_back(mk(1'b0, 8'h5A, 1'b1));
    c0 = cyc;
    wait_ack(50, t);
    check("post_reset_latency", t - c0, 32'd3);
    a_req = 1'b0;
    repeat (3) @(negedge clk);

    // Back-to-back A reads with a_req held.
    issue(1'b0, 8'h10, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) sb.push_back(mk(1'b0, 8'h5A, 1'b1));
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      wait_ack(50, t);
      if (i > 0) check("b2b_spacing", t - prev, 32'd5);
      prev = t;
    end
    a_req = 1'b0;
    repeat (4) @(negedge clk);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
